// File: rtl/conv33_sched.sv
// conv33_sched: sequences one 3x3 convolution pass. It loads the weights,
// issues one window per valid output position under a credit limit, and
// reports done once every issued result has drained.
module conv33_sched #(
  parameter int unsigned IMG_W        = 28,
  parameter int unsigned IMG_H        = 28,
  parameter int unsigned NUM_WEIGHTS  = 9,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             wt_valid_in,
  output logic             wt_ready_out,
  output logic             wt_load_en,
  output logic [3:0]       wt_idx,
  output logic             win_valid_out,
  input  logic             win_ready_in,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             conv_en,
  input  logic             res_valid_in,
  input  logic             res_ready_in,
  output logic [3:0]       inflight,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int unsigned TOTAL = (IMG_H - 2) * (IMG_W - 2);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 3);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 3);
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [3:0]       LAST_WT  = 4'(NUM_WEIGHTS - 1);
  localparam logic [3:0]       MAX_CR   = 4'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wt_idx_d, inflight_d;
  logic [CNT_W-1:0] row_d, col_d, res_cnt_d;
  logic             busy_d, done_d, wt_ready_d;
  logic             drain;

  // Handshake strobes; a drain with no credit outstanding is ignored
  always_comb begin
    wt_load_en    = wt_valid_in & wt_ready_out;
    win_valid_out = (state_q == S_RUN) && (inflight < MAX_CR);
    conv_en       = win_valid_out & win_ready_in;
    drain         = res_valid_in & res_ready_in & (inflight != 4'd0);
  end

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d    = state_q;
    wt_idx_d   = wt_idx;
    row_d      = win_row;
    col_d      = win_col;
    inflight_d = inflight;
    res_cnt_d  = res_cnt;

    if (conv_en && !drain) begin
      inflight_d = inflight + 4'd1;
    end else if (drain && !conv_en) begin
      inflight_d = inflight - 4'd1;
    end
    if (drain) begin
      res_cnt_d = res_cnt + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD_W;
          wt_idx_d   = 4'd0;
          row_d      = '0;
          col_d      = '0;
          res_cnt_d  = '0;
          inflight_d = 4'd0;
        end
      end
      S_LOAD_W: begin
        if (wt_load_en) begin
          wt_idx_d = wt_idx + 4'd1;
          if (wt_idx == LAST_WT) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (conv_en) begin
          if (win_col == LAST_COL) begin
            col_d = '0;
            row_d = win_row + CNT_W'(1);
            if (win_row == LAST_ROW) begin
              state_d = S_DRAIN;
            end
          end else begin
            col_d = win_col + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Look at next-cycle values so done follows the last drain by one cycle
        if ((inflight_d == 4'd0) && (res_cnt_d == TOTAL_C)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    wt_ready_d = (state_d == S_LOAD_W);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      wt_ready_out <= 1'b0;
      wt_idx       <= 4'd0;
      win_row      <= '0;
      win_col      <= '0;
      inflight     <= 4'd0;
      res_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      busy         <= busy_d;
      done         <= done_d;
      wt_ready_out <= wt_ready_d;
      wt_idx       <= wt_idx_d;
      win_row      <= row_d;
      win_col      <= col_d;
      inflight     <= inflight_d;
      res_cnt      <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_conv33_sched.sv
// Directed bench for conv33_sched on a 5x5 map (3x3 = 9 windows), 4 credits.
module tb_conv33_sched;

  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done;
  logic             wt_valid_in, wt_ready_out, wt_load_en;
  logic [3:0]       wt_idx;
  logic             win_valid_out, win_ready_in;
  logic [CNT_W-1:0] win_row, win_col;
  logic             conv_en;
  logic             res_valid_in, res_ready_in;
  logic [3:0]       inflight;
  logic [CNT_W-1:0] res_cnt;

  int checks = 0;
  int errors = 0;
  int lcnt   = 0;
  int dcnt   = 0;
  int qrow[$];
  int qcol[$];

  conv33_sched #(
    .IMG_W(5), .IMG_H(5), .NUM_WEIGHTS(9), .MAX_INFLIGHT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wt_valid_in(wt_valid_in), .wt_ready_out(wt_ready_out),
    .wt_load_en(wt_load_en), .wt_idx(wt_idx),
    .win_valid_out(win_valid_out), .win_ready_in(win_ready_in),
    .win_row(win_row), .win_col(win_col), .conv_en(conv_en),
    .res_valid_in(res_valid_in), .res_ready_in(res_ready_in),
    .inflight(inflight), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  // Record handshakes as they occur at the clock edge
  always @(posedge clk) begin
    if (conv_en) begin
      qrow.push_back(int'(win_row));
      qcol.push_back(int'(win_col));
    end
    if (wt_load_en) lcnt++;
    if (done) dcnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_b2b(input bit chk);
    for (int i = 0; i < 9; i++) begin
      wt_valid_in = 1'b1;
      #1;
      if (chk) begin
        check("wt_idx", int'(wt_idx), i);
        check("wt_load_en", int'(wt_load_en), 1);
      end
      cyc();
    end
    wt_valid_in = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    for (int k = 0; k < 200; k++) begin
      if (done) break;
      cyc();
    end
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_busy_in_done"}, int'(busy), 1);
  endtask

  task automatic check_coords(input string tag);
    check({tag, "_issues"}, qrow.size(), 9);
    for (int i = 0; i < qrow.size() && i < 9; i++) begin
      check({tag, "_row"}, qrow[i], i / 3);
      check({tag, "_col"}, qcol[i], i % 3);
    end
  endtask

  task automatic check_after_done(input string tag);
    cyc();
    check({tag, "_done_pulses"}, dcnt, 1);
    check({tag, "_done_low"}, int'(done), 0);
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_res_cnt_hold"}, int'(res_cnt), 9);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_wt_ready"}, int'(wt_ready_out), 0);
    check({tag, "_wt_idx"}, int'(wt_idx), 0);
    check({tag, "_win_valid"}, int'(win_valid_out), 0);
    check({tag, "_win_row"}, int'(win_row), 0);
    check({tag, "_win_col"}, int'(win_col), 0);
    check({tag, "_inflight"}, int'(inflight), 0);
    check({tag, "_res_cnt"}, int'(res_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wt_valid_in = 1'b0; win_ready_in = 1'b0;
    res_valid_in = 1'b1; res_ready_in = 1'b0;
    cyc(); cyc();
    check_reset_vals("reset");
    rst = 1'b0;
    cyc();

    // Pass 1: back-to-back weights, free-flowing windows and results
    win_ready_in = 1'b1; res_ready_in = 1'b1;
    qrow.delete(); qcol.delete(); dcnt = 0; lcnt = 0;
    pulse_start();
    check("p1_wt_ready", int'(wt_ready_out), 1);
    check("p1_busy", int'(busy), 1);
    load_b2b(1'b1);
    #1;
    check("p1_wt_ready_drop", int'(wt_ready_out), 0);
    check("p1_first_win_valid", int'(win_valid_out), 1);
    run_to_done("p1");
    check("p1_res_cnt", int'(res_cnt), 9);
    check("p1_loads", lcnt, 9);
    check_coords("p1");
    check_after_done("p1");

    // Pass 2: stalled weights, then credit limit with results blocked
    win_ready_in = 1'b0; res_ready_in = 1'b0;
    qrow.delete(); qcol.delete(); dcnt = 0; lcnt = 0;
    pulse_start();
    for (int i = 0; i < 40 && lcnt < 9; i++) begin
      wt_valid_in = (i % 2 == 0);
      cyc();
    end
    wt_valid_in = 1'b0;
    check("p2_loads", lcnt, 9);
    check("p2_wt_ready_drop", int'(wt_ready_out), 0);
    check("p2_run_win_valid", int'(win_valid_out), 1);

    win_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    check("p2_issues_at_limit", qrow.size(), 4);
    check("p2_inflight_full", int'(inflight), 4);
    check("p2_win_valid_full", int'(win_valid_out), 0);
    check("p2_loads_after", lcnt, 9);

    // Drain at full credit: no issue this cycle
    res_ready_in = 1'b1;
    #1;
    check("p2_full_drain_no_valid", int'(win_valid_out), 0);
    check("p2_full_drain_no_conv", int'(conv_en), 0);
    cyc();
    check("p2_inflight_3", int'(inflight), 3);
    check("p2_res_cnt_1", int'(res_cnt), 1);
    win_ready_in = 1'b0;
    cyc();
    check("p2_inflight_2", int'(inflight), 2);
    win_ready_in = 1'b1;
    #1;
    check("p2_issue_and_drain", int'(conv_en), 1);
    cyc();
    check("p2_inflight_still_2", int'(inflight), 2);
    check("p2_res_cnt_3", int'(res_cnt), 3);
    win_ready_in = 1'b0; res_ready_in = 1'b0;
    check("p2_row_before", int'(win_row), 1);
    check("p2_col_before", int'(win_col), 2);

    // start during RUN is ignored
    pulse_start();
    cyc();
    check("p2_start_inflight", int'(inflight), 2);
    check("p2_start_res_cnt", int'(res_cnt), 3);
    check("p2_start_row", int'(win_row), 1);
    check("p2_start_col", int'(win_col), 2);
    check("p2_start_busy", int'(busy), 1);
    check("p2_start_wt_ready", int'(wt_ready_out), 0);

    win_ready_in = 1'b1; res_ready_in = 1'b1;
    run_to_done("p2");
    check("p2_res_cnt", int'(res_cnt), 9);
    check_coords("p2");
    check_after_done("p2");

    // Pass 3: new start clears res_cnt; reset mid-RUN with 3 credits used
    win_ready_in = 1'b0; res_ready_in = 1'b0;
    pulse_start();
    check("p3_res_cnt_cleared", int'(res_cnt), 0);
    check("p3_wt_ready", int'(wt_ready_out), 1);
    load_b2b(1'b0);
    win_ready_in = 1'b1;
    cyc(); cyc(); cyc();
    win_ready_in = 1'b0;
    check("p3_inflight_3", int'(inflight), 3);
    check("p3_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    cyc();
    rst = 1'b0;
    cyc();

    // Pass 4: clean full pass after reset
    win_ready_in = 1'b1; res_ready_in = 1'b1;
    qrow.delete(); qcol.delete(); dcnt = 0; lcnt = 0;
    pulse_start();
    check("p4_inflight_start", int'(inflight), 0);
    load_b2b(1'b0);
    run_to_done("p4");
    check("p4_res_cnt", int'(res_cnt), 9);
    check("p4_loads", lcnt, 9);
    check_coords("p4");
    check_after_done("p4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv33_sched.md
Name: conv33_sched

Overview:
Sequencer for one 3x3 convolution pass over an IMG_H x IMG_W feature map.
- On start, accepts NUM_WEIGHTS serial weight bytes into the weight store.
- Then issues one window per valid output position (row-major, stride 1, no padding) to the calc datapath.
- Limits results in flight with a credit counter and signals done once every result has drained downstream.
- Sits between the line-buffer/window source, the weight store, the 3x3 MAC and the output stage.

Parameters:
IMG_W, 28, input feature-map width (>=3)
IMG_H, 28, input feature-map height (>=3)
NUM_WEIGHTS, 9, weight bytes loaded per pass
MAX_INFLIGHT, 4, max issued-but-not-drained windows (1..15)
CNT_W, 10, width of row/col/result counters (must hold IMG_W*IMG_H)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin pass; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on DONE->IDLE
wt_valid_in  in  1  weight byte available
wt_ready_out  out  1  high only in LOAD_W
wt_load_en  out  1  = wt_valid_in & wt_ready_out; store writes on this cycle
wt_idx  out  4  index of the weight being accepted (0..NUM_WEIGHTS-1)
win_valid_out  out  1  request window at (win_row, win_col)
win_ready_in  in  1  window source presents data this cycle
win_row  out  CNT_W  top-left row of requested window
win_col  out  CNT_W  top-left col of requested window
conv_en  out  1  = win_valid_out & win_ready_in; calc captures window
res_valid_in  in  1  calc result valid
res_ready_in  in  1  output stage accepts result
inflight  out  4  current credit usage
res_cnt  out  CNT_W  results drained this pass

Behaviour:
- Reset values (async): state=IDLE, busy=0, done=0, wt_ready_out=0, wt_idx=0, win_valid_out=0, win_row=0, win_col=0, inflight=0, res_cnt=0. Reset mid-pass aborts immediately; no residual credits.
- IDLE: start=1 -> LOAD_W. Clears wt_idx, win_row, win_col, res_cnt and inflight. start in any other state is ignored.
- LOAD_W: wt_ready_out=1.
  - Each wt_load_en increments wt_idx.
  - On the accept with wt_idx=NUM_WEIGHTS-1 -> RUN next cycle; wt_ready_out drops that cycle.
  - Gaps in wt_valid_in just stall.
- RUN: win_valid_out = (inflight < MAX_INFLIGHT).
  - On conv_en, advance col. At col=IMG_W-3, col wraps to 0 and row increments.
  - The issue with row=IMG_H-3, col=IMG_W-3 is the last one -> DRAIN next cycle.
  - Total issues = (IMG_H-2)*(IMG_W-2).
  - win_row/win_col are registered and stable while win_valid_out=1 and win_ready_in=0.
- drain event = res_valid_in & res_ready_in; res_cnt increments on each drain event.
- Credit update each cycle:
  - conv_en only: inflight+1.
  - drain only: inflight-1.
  - both: unchanged.
  - Never exceeds MAX_INFLIGHT; never underflows. A drain with inflight=0 is a protocol error: ignored, inflight stays 0, res_cnt unchanged.
- When inflight=MAX_INFLIGHT and a drain occurs in the same cycle, win_valid_out stays 0 that cycle (combinational from the registered inflight). Issue resumes next cycle.
- DRAIN: no issues. When inflight=0 and res_cnt=(IMG_H-2)*(IMG_W-2) -> DONE.
- DONE: one cycle, done=1, busy=1 -> IDLE. busy=0 from the following cycle. res_cnt holds until the next start.
- Latency:
  - start to wt_ready_out: 1 cycle.
  - Last weight accept to first win_valid_out: 1 cycle.
  - Last drain to done pulse: 1 cycle.
- No combinational path from inputs to outputs except wt_load_en, conv_en and win_valid_out's dependence on registered inflight.

Test Plan:
1. IMG_W=IMG_H=4, 9 weights back-to-back, win_ready_in=1, results drained 2 cycles after issue -> wt_idx 0..8, 4 conv_en with (row,col)=(0,0),(0,1),(1,0),(1,1), res_cnt=4, single done pulse, busy low after.
2. Weight stall: wt_valid_in toggles 1,0,1,... -> exactly 9 wt_load_en, RUN entered 1 cycle after the 9th accept.
3. Credit limit MAX_INFLIGHT=4, res_ready_in=0 for 20 cycles -> exactly 4 conv_en, inflight=4, win_valid_out=0. Release res_ready_in -> issues resume, pass completes with res_cnt=(IMG_H-2)*(IMG_W-2).
4. Simultaneous issue and drain at inflight=2 -> inflight stays 2. At inflight=4 with drain -> no issue that cycle, inflight=3.
5. start pulsed during RUN -> ignored, counters unaffected. start in IDLE after done -> new pass, res_cnt cleared to 0.
6. Assert rst during RUN with inflight=3 -> all outputs at reset values asynchronously; next start runs a clean full pass.
